// File: rtl/core_pkg.sv
// Shared core types and constants: register-file addressing, hazard controller
// state encoding and the bundle of per-stage pipeline control strobes.
package core_pkg;

  localparam int REG_ADDR_WIDTH     = 5;
  localparam int MULDIV_LAT_DEFAULT = 4;
  localparam int MD_CNT_WIDTH       = 4;

  typedef enum logic [0:0] {CTRL_RUN, CTRL_MD_BUSY} ctrl_state_e;

  // Bit order is also the order the outputs appear on the hazard_ctrl port list.
  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic id_ex_stall;
    logic ex_mem_stall;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
    logic mem_wb_flush;
    logic pc_sel_target;
    logic muldiv_done;
  } ctrl_t;

  function automatic logic load_use_hit(
    input logic                      mem_read,
    input logic [REG_ADDR_WIDTH-1:0] rd,
    input logic [REG_ADDR_WIDTH-1:0] rs1,
    input logic                      rs1_used,
    input logic [REG_ADDR_WIDTH-1:0] rs2,
    input logic                      rs2_used
  );
    return mem_read && (rd != '0) &&
           ((rs1_used && (rs1 == rd)) || (rs2_used && (rs2 == rd)));
  endfunction

endpackage

// File: rtl/perf_counter.sv
// Free-running event counter: adds one on each cycle inc_i is high, wraps
// modulo 2^CNT_WIDTH, clears asynchronously on reset.
module perf_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc_i,
  output logic [CNT_WIDTH-1:0] cnt_o
);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: combinational stall/flush/bubble strobes from the
// ID/EX/MEM status, with a small FSM tracking multi-cycle mul/div occupancy of EX.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int MULDIV_LAT = MULDIV_LAT_DEFAULT,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
  input  logic                      id_rs1_used,
  input  logic                      id_rs2_used,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
  input  logic                      ex_mem_read,
  input  logic                      ex_branch_taken,
  input  logic                      ex_muldiv,
  input  logic                      mem_req,
  input  logic                      mem_ready,
  output logic                      pc_stall,
  output logic                      if_id_stall,
  output logic                      id_ex_stall,
  output logic                      ex_mem_stall,
  output logic                      if_id_flush,
  output logic                      id_ex_flush,
  output logic                      ex_mem_flush,
  output logic                      mem_wb_flush,
  output logic                      pc_sel_target,
  output logic                      muldiv_done,
  output logic [CNT_WIDTH-1:0]      stall_cnt,
  output logic [CNT_WIDTH-1:0]      flush_cnt
);

  localparam logic [MD_CNT_WIDTH-1:0] MD_LOAD = MD_CNT_WIDTH'(MULDIV_LAT - 2);

  ctrl_state_e             state_q, state_d;
  logic [MD_CNT_WIDTH-1:0] md_cnt_q, md_cnt_d;
  ctrl_t                   ctrl_c;
  ctrl_t                   ctrl;
  logic                    mem_wait;
  logic                    lu_hit;

  assign mem_wait = mem_req && !mem_ready;
  assign lu_hit   = load_use_hit(ex_mem_read, ex_rd_addr, id_rs1_addr, id_rs1_used,
                                 id_rs2_addr, id_rs2_used);

  always_comb begin
    ctrl_c   = '0;
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    if (mem_wait) begin
      // Whole front end freezes; only the stalled access's successor slot gets a bubble.
      ctrl_c.pc_stall     = 1'b1;
      ctrl_c.if_id_stall  = 1'b1;
      ctrl_c.id_ex_stall  = 1'b1;
      ctrl_c.ex_mem_stall = 1'b1;
      ctrl_c.mem_wb_flush = 1'b1;
    end else if (state_q == CTRL_MD_BUSY) begin
      ctrl_c.pc_stall     = 1'b1;
      ctrl_c.if_id_stall  = 1'b1;
      ctrl_c.id_ex_stall  = 1'b1;
      ctrl_c.ex_mem_flush = 1'b1;
      if (md_cnt_q == '0) begin
        ctrl_c.muldiv_done = 1'b1;
        state_d            = CTRL_RUN;
      end else begin
        md_cnt_d = md_cnt_q - 1'b1;
      end
    end else if (ex_muldiv) begin
      // First occupancy cycle counts toward MULDIV_LAT, hence the load of LAT-2.
      ctrl_c.pc_stall     = 1'b1;
      ctrl_c.if_id_stall  = 1'b1;
      ctrl_c.id_ex_stall  = 1'b1;
      ctrl_c.ex_mem_flush = 1'b1;
      state_d             = CTRL_MD_BUSY;
      md_cnt_d            = MD_LOAD;
    end else if (ex_branch_taken) begin
      ctrl_c.pc_sel_target = 1'b1;
      ctrl_c.if_id_flush   = 1'b1;
      ctrl_c.id_ex_flush   = 1'b1;
    end else if (lu_hit) begin
      ctrl_c.pc_stall    = 1'b1;
      ctrl_c.if_id_stall = 1'b1;
      ctrl_c.id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= CTRL_RUN;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  // Strobes are forced quiet while reset is held, independent of input activity.
  assign ctrl = rst_n ? ctrl_c : '0;

  assign pc_stall      = ctrl.pc_stall;
  assign if_id_stall   = ctrl.if_id_stall;
  assign id_ex_stall   = ctrl.id_ex_stall;
  assign ex_mem_stall  = ctrl.ex_mem_stall;
  assign if_id_flush   = ctrl.if_id_flush;
  assign id_ex_flush   = ctrl.id_ex_flush;
  assign ex_mem_flush  = ctrl.ex_mem_flush;
  assign mem_wb_flush  = ctrl.mem_wb_flush;
  assign pc_sel_target = ctrl.pc_sel_target;
  assign muldiv_done   = ctrl.muldiv_done;

  perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (ctrl.pc_stall),
    .cnt_o (stall_cnt)
  );

  perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (ctrl.if_id_flush),
    .cnt_o (flush_cnt)
  );

  a_no_muldiv_branch: assert property (@(posedge clk) disable iff (!rst_n)
    !(ex_muldiv && ex_branch_taken));

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboarded bench for hazard_ctrl: per-cycle expected strobe vectors are queued
// when stimulus is applied and popped against the live outputs.
module tb_hazard_ctrl;
  import core_pkg::*;

  localparam int CW = 32;

  // {pc_stall,if_id_stall,id_ex_stall,ex_mem_stall,if_id_flush,id_ex_flush,
  //  ex_mem_flush,mem_wb_flush,pc_sel_target,muldiv_done}
  localparam logic [9:0] O_NONE = 10'b0000000000;
  localparam logic [9:0] O_MEMW = 10'b1111000100;
  localparam logic [9:0] O_MD   = 10'b1110001000;
  localparam logic [9:0] O_DONE = 10'b1110001001;
  localparam logic [9:0] O_BR   = 10'b0000110010;
  localparam logic [9:0] O_LU   = 10'b1100010000;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic id_rs1_used, id_rs2_used, ex_mem_read, ex_branch_taken, ex_muldiv;
  logic mem_req, mem_ready;
  logic pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic pc_sel_target, muldiv_done;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [9:0] obs;

  logic [9:0]    exp_q[$];
  logic [CW-1:0] exp_stall, exp_flush;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign obs = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush,
                id_ex_flush, ex_mem_flush, mem_wb_flush, pc_sel_target, muldiv_done};

  hazard_ctrl #(.MULDIV_LAT(4), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd_addr(ex_rd_addr), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .ex_muldiv(ex_muldiv),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
    .ex_mem_stall(ex_mem_stall), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
    .pc_sel_target(pc_sel_target), .muldiv_done(muldiv_done),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic idle_inputs();
    id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; ex_rd_addr = 5'd0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; ex_mem_read = 1'b0;
    ex_branch_taken = 1'b0; ex_muldiv = 1'b0; mem_req = 1'b0; mem_ready = 1'b1;
  endtask

  task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs1,
                              input logic u1, input logic [4:0] rs2, input logic u2);
    ex_mem_read = 1'b1; ex_rd_addr = rd;
    id_rs1_addr = rs1; id_rs1_used = u1; id_rs2_addr = rs2; id_rs2_used = u2;
  endtask

  // Inputs must already be set (after the preceding negedge); queue the expectation,
  // compare, then let one edge go by and return the inputs to idle.
  task automatic step(input string name, input logic [9:0] exp);
    logic [9:0] e;
    exp_q.push_back(exp);
    #1;
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL %s: outputs got %b expected %b", name, obs, e);
    end
    if (e[9]) exp_stall++;
    if (e[5]) exp_flush++;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic check_counts(input string name);
    checks++;
    if (stall_cnt !== exp_stall || flush_cnt !== exp_flush) begin
      errors++;
      $display("FAIL %s: stall_cnt/flush_cnt got %0d/%0d expected %0d/%0d",
               name, stall_cnt, flush_cnt, exp_stall, exp_flush);
    end
  endtask

  task automatic check_state(input string name, input ctrl_state_e st,
                             input logic [3:0] md);
    checks++;
    if (dut.state_q !== st || dut.md_cnt_q !== md) begin
      errors++;
      $display("FAIL %s: state/md_cnt got %0d/%0d expected %0d/%0d",
               name, dut.state_q, dut.md_cnt_q, st, md);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    ex_branch_taken = 1'b1;
    mem_req = 1'b1; mem_ready = 1'b0;
    exp_stall = '0; exp_flush = '0;
    #12;
    checks++;
    if (obs !== O_NONE) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected %b", obs, O_NONE);
    end
    check_counts("reset_counts");
    check_state("reset_state", CTRL_RUN, 4'd0);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_branch();
    @(negedge clk); ex_branch_taken = 1'b1;
    step("branch_taken", O_BR);
    check_counts("branch_counts");
    @(negedge clk);
    step("branch_after", O_NONE);
  endtask

  task automatic test_load_use();
    @(negedge clk); set_load_use(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    step("lu_rs1", O_LU);
    check_counts("lu_counts");
    @(negedge clk); set_load_use(5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
    step("lu_x0", O_NONE);
    @(negedge clk); set_load_use(5'd9, 5'd3, 1'b1, 5'd9, 1'b1);
    step("lu_rs2", O_LU);
    @(negedge clk); set_load_use(5'd9, 5'd9, 1'b0, 5'd9, 1'b0);
    step("lu_unused", O_NONE);
    @(negedge clk); set_load_use(5'd7, 5'd5, 1'b1, 5'd6, 1'b1);
    step("lu_nomatch", O_NONE);
  endtask

  task automatic test_branch_load_use();
    @(negedge clk); set_load_use(5'd5, 5'd5, 1'b1, 5'd5, 1'b1); ex_branch_taken = 1'b1;
    step("br_lu", O_BR);
    check_counts("br_lu_counts");
  endtask

  task automatic test_muldiv();
    @(negedge clk); ex_muldiv = 1'b1;
    step("md_c1", O_MD);
    check_state("md_enter", CTRL_MD_BUSY, 4'd2);
    @(negedge clk); ex_branch_taken = 1'b1;
    step("md_c2_br_ignored", O_MD);
    @(negedge clk); set_load_use(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    step("md_c3", O_MD);
    @(negedge clk);
    step("md_c4_done", O_DONE);
    check_state("md_exit", CTRL_RUN, 4'd0);
    check_counts("md_counts");
    @(negedge clk);
    step("md_after", O_NONE);
  endtask

  task automatic test_mem_wait();
    @(negedge clk); mem_req = 1'b1; mem_ready = 1'b0; ex_branch_taken = 1'b1;
    step("memw_run_branch", O_MEMW);
    @(negedge clk); mem_req = 1'b1; mem_ready = 1'b1; ex_branch_taken = 1'b1;
    step("mem_ready_branch", O_BR);
    @(negedge clk); ex_muldiv = 1'b1;
    step("mw_md_c1", O_MD);
    @(negedge clk);
    step("mw_md_c2", O_MD);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); mem_req = 1'b1; mem_ready = 1'b0;
      step("mw_freeze", O_MEMW);
      check_state("mw_md_frozen", CTRL_MD_BUSY, 4'd1);
    end
    @(negedge clk);
    step("mw_md_c3", O_MD);
    @(negedge clk);
    step("mw_md_done", O_DONE);
    check_state("mw_exit", CTRL_RUN, 4'd0);
    check_counts("mw_counts");
  endtask

  task automatic test_reset_mid();
    @(negedge clk); ex_muldiv = 1'b1;
    step("rm_md_c1", O_MD);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== O_NONE) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %b expected %b", obs, O_NONE);
    end
    exp_stall = '0; exp_flush = '0;
    check_counts("reset_mid_counts");
    check_state("reset_mid_state", CTRL_RUN, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      step("rm_no_done", O_NONE);
    end
    check_counts("rm_after_counts");
  endtask

  task automatic test_back_to_back();
    @(negedge clk); set_load_use(5'd12, 5'd0, 1'b0, 5'd12, 1'b1);
    step("b2b_lu", O_LU);
    @(negedge clk); ex_branch_taken = 1'b1;
    step("b2b_br", O_BR);
    @(negedge clk); ex_muldiv = 1'b1;
    step("b2b_md1", O_MD);
    @(negedge clk); step("b2b_md2", O_MD);
    @(negedge clk); step("b2b_md3", O_MD);
    @(negedge clk); step("b2b_md4", O_DONE);
    @(negedge clk); ex_muldiv = 1'b1;
    step("b2b_md_again", O_MD);
    check_state("b2b_reenter", CTRL_MD_BUSY, 4'd2);
    @(negedge clk); step("b2b_m2", O_MD);
    @(negedge clk); step("b2b_m3", O_MD);
    @(negedge clk); step("b2b_m4", O_DONE);
    @(negedge clk); ex_branch_taken = 1'b1;
    step("b2b_br2", O_BR);
    check_counts("b2b_counts");
  endtask

  initial begin
    test_reset();
    test_branch();
    test_load_use();
    test_branch_load_use();
    test_muldiv();
    test_mem_wait();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
